// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: store sizes, load funct3
// codes, FSM state encoding and small size/alignment helpers.
package load_store_unit_pkg;

    localparam logic [1:0] STORE_NONE = 2'd0;
    localparam logic [1:0] STORE_B    = 2'd1;
    localparam logic [1:0] STORE_H    = 2'd2;
    localparam logic [1:0] STORE_W    = 2'd3;

    localparam logic [2:0] FUNCT_LB  = 3'd0;
    localparam logic [2:0] FUNCT_LH  = 3'd1;
    localparam logic [2:0] FUNCT_LW  = 3'd2;
    localparam logic [2:0] FUNCT_LBU = 3'd4;
    localparam logic [2:0] FUNCT_LHU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    // Access size of a load; reserved funct3 codes behave as LW.
    function automatic logic [1:0] load_size(input logic [2:0] f);
        logic [1:0] s;
        case (f)
            FUNCT_LB, FUNCT_LBU: s = STORE_B;
            FUNCT_LH, FUNCT_LHU: s = STORE_H;
            FUNCT_LW:            s = STORE_W;
            default:             s = STORE_W;
        endcase
        return s;
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lo);
        return ((size == STORE_H) && lo[0]) ||
               ((size == STORE_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication, plus
// load lane extraction with sign/zero extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_funct,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Store side: enables follow size and low address bits; data is
    // replicated so every enabled lane carries the right bytes.
    always_comb begin
        be        = 4'h0;
        wdata_rep = wdata;
        case (size)
            STORE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            STORE_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            STORE_W: begin
                be        = 4'hF;
                wdata_rep = wdata;
            end
            default: be = 4'h0;
        endcase
    end

    // Load side: pick the addressed lane and extend to 32 bits.
    always_comb begin
        ld_b    = 8'(rdata >> {ld_addr_lo, 3'b000});
        ld_h    = 16'(rdata >> {ld_addr_lo[1], 4'b0000});
        ld_data = rdata;
        case (ld_funct)
            FUNCT_LB:  ld_data = {{24{ld_b[7]}}, ld_b};
            FUNCT_LBU: ld_data = {24'h0, ld_b};
            FUNCT_LH:  ld_data = {{16{ld_h[15]}}, ld_h};
            FUNCT_LHU: ld_data = {16'h0, ld_h};
            default:   ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding req/ack data-bus access with stall.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses with err.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  storeops,
    input  logic [2:0]  load_funct,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    lsu_state_e  state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        lv_q, lv_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  lo_q, lo_d;
    logic        load_q, load_d;

    logic        noop;
    logic        start;
    logic        trap;
    logic [1:0]  op_size;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ld;

    assign noop    = memwrite && (storeops == STORE_NONE);
    assign start   = (memread || memwrite) && !noop;
    assign op_size = memwrite ? storeops : load_size(load_funct);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(op_size, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign stall = (memread || memwrite) && (state_q != LSU_RESP) &&
                   !((state_q == LSU_IDLE) && noop);

    lsu_lane_align u_align (
        .size       (op_size),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .ld_funct   (funct_q),
        .ld_addr_lo (lo_q),
        .rdata      (mem_rdata),
        .ld_data    (al_ld)
    );

    // Next-state and registered-output logic for IDLE -> REQ -> RESP.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lv_d    = 1'b0;
        ld_d    = ld_q;
        err_d   = 1'b0;
        funct_d = funct_q;
        lo_d    = lo_q;
        load_d  = load_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    funct_d = load_funct;
                    lo_d    = addr[1:0];
                    load_d  = !memwrite;
                    if (trap) begin
                        err_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = memwrite;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        timer_d = 8'd0;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                timer_d = timer_q + 8'd1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = LSU_RESP;
                    if (load_q) begin
                        lv_d = 1'b1;
                        ld_d = al_ld;
                    end
                end else if (timer_d == TMO) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State and output registers; reset drops any bus request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            timer_q <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            lv_q    <= 1'b0;
            ld_q    <= 32'h0;
            err_q   <= 1'b0;
            funct_q <= 3'd0;
            lo_q    <= 2'd0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lv_q    <= lv_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            funct_q <= funct_d;
            lo_q    <= lo_d;
            load_q  <= load_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign load_valid = lv_q;
    assign load_data  = ld_q;
    assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYC = 4).
// Honours LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        memread;
    logic        memwrite;
    logic [1:0]  storeops;
    logic [2:0]  load_funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk;
    int n_fail;

    typedef struct {
        logic        we;
        logic        st;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        int          reqc;
        int          stall;
        int          err;
        int          lv;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memread    (memread),
        .memwrite   (memwrite),
        .storeops   (storeops),
        .load_funct (load_funct),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] fn,
                                             input logic [1:0] lo,
                                             input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [7:0]  by;
        logic [15:0] hw;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        by = b[lo];
        hw = {b[{lo[1], 1'b1}], b[{lo[1], 1'b0}]};
        case (fn)
            3'd0:    return {{24{by[7]}}, by};
            3'd4:    return {24'h0, by};
            3'd1:    return {{16{hw[15]}}, hw};
            3'd5:    return {16'h0, hw};
            default: return rd;
        endcase
    endfunction

    task automatic run(input string nm, input logic mr, input logic mw,
                       input logic [1:0] so, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int d, input bit tmo);
        exp_t e;
        int   sz;
        bit   mis;
        int   st_c, rq_c, lv_c, er_c, post;
        bit   done, fin, stable;
        logic        c_we;
        logic [31:0] c_addr, c_wd, c_ld;
        logic [3:0]  c_be;

        sz = mw ? int'(so) : ((fn == 3'd0 || fn == 3'd4) ? 1 :
                              (fn == 3'd1 || fn == 3'd5) ? 2 : 3);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (sz == 2 && a[0]) || (sz == 3 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.we    = mw;
        e.st    = mw;
        e.addr  = {a[31:2], 2'b00};
        e.data  = exp_load(fn, a[1:0], rd);
        e.be    = 4'h0;
        for (int i = 0; i < 4; i++)
            e.be[i] = (sz == 3) || (sz == 1 && i == int'(a[1:0])) ||
                      (sz == 2 && (i / 2) == int'(a[1]));
        e.wdata = (sz == 1) ? {4{wd[7:0]}} :
                  (sz == 2) ? {2{wd[15:0]}} : wd;
        if (mw && so == 2'd0) begin
            e.reqc = 0; e.stall = 0; e.err = 0; e.lv = 0;
        end else if (mis) begin
            e.reqc = 0; e.stall = 1; e.err = 1; e.lv = 0;
        end else if (tmo) begin
            e.reqc = TMO; e.stall = TMO + 1; e.err = 1; e.lv = 0;
        end else begin
            e.reqc = d + 1; e.stall = d + 2; e.err = 0;
            e.lv = mw ? 0 : 1;
        end
        sb.push_back(e);

        st_c = 0; rq_c = 0; lv_c = 0; er_c = 0; post = 0;
        done = 0; fin = 0; stable = 1;
        c_we = 0; c_addr = 0; c_wd = 0; c_be = 0; c_ld = 0;

        @(negedge clk);
        memread = mr; memwrite = mw; storeops = so;
        load_funct = fn; addr = a; wdata = wd;
        mem_ack = 0; mem_rdata = rd;
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            if (!done && stall) st_c++;
            if (load_valid) begin
                lv_c++;
                c_ld = load_data;
            end
            if (err) er_c++;
            if (mem_req) begin
                rq_c++;
                if (rq_c == 1) begin
                    c_we = mem_we; c_addr = mem_addr;
                    c_be = mem_be; c_wd = mem_wdata;
                end else if (mem_we !== c_we || mem_addr !== c_addr ||
                             mem_be !== c_be || mem_wdata !== c_wd) begin
                    stable = 0;
                end
                mem_ack = !tmo && (rq_c == d + 1);
            end else begin
                mem_ack = 0;
            end
            if (done) begin
                post++;
                if (post > 2) fin = 1;
            end else if (!stall) begin
                done = 1;
                memread = 0;
                memwrite = 0;
            end
            @(negedge clk);
        end
        memread = 0; memwrite = 0; mem_ack = 0;
        if (!fin) chk({nm, ".budget"}, 32'd0, 32'd1);

        e = sb.pop_front();
        chk({nm, ".stall"}, 32'(st_c), 32'(e.stall));
        chk({nm, ".reqc"}, 32'(rq_c), 32'(e.reqc));
        if (e.reqc > 0) begin
            chk({nm, ".we"}, 32'(c_we), 32'(e.we));
            chk({nm, ".addr"}, c_addr, e.addr);
            chk({nm, ".stable"}, 32'(stable), 32'd1);
            if (e.st) begin
                chk({nm, ".be"}, 32'(c_be), 32'(e.be));
                chk({nm, ".wdata"}, c_wd, e.wdata);
            end
        end
        chk({nm, ".lv"}, 32'(lv_c), 32'(e.lv));
        if (e.lv > 0) chk({nm, ".data"}, c_ld, e.data);
        chk({nm, ".err"}, 32'(er_c), 32'(e.err));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 0; memread = 0; memwrite = 0; storeops = 0;
        load_funct = 0; addr = 0; wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.we", 32'(mem_we), 32'd0);
        chk("rst.be", 32'(mem_be), 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.lv", 32'(load_valid), 32'd0);
        chk("rst.ld", load_data, 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1;

        run("sw",   0, 1, 2'd3, 3'd0, 32'h104, 32'hDEADBEEF, 32'h0, 2, 0);
        run("sb",   0, 1, 2'd1, 3'd0, 32'h203, 32'h000000A5, 32'h0, 0, 0);
        run("sh",   0, 1, 2'd2, 3'd0, 32'h202, 32'h1234BEEF, 32'h0, 1, 0);
        run("lb",   1, 0, 2'd0, 3'd0, 32'h001, 32'h0, 32'h000080FF, 1, 0);
        run("lbu",  1, 0, 2'd0, 3'd4, 32'h001, 32'h0, 32'h000080FF, 0, 0);
        run("lh",   1, 0, 2'd0, 3'd1, 32'h002, 32'h0, 32'h80010000, 0, 0);
        run("lhu",  1, 0, 2'd0, 3'd5, 32'h002, 32'h0, 32'h80010000, 2, 0);
        run("lw",   1, 0, 2'd0, 3'd2, 32'h100, 32'h0, 32'h12345678, 1, 0);
        run("lrsv", 1, 0, 2'd0, 3'd7, 32'h108, 32'h0, 32'hCAFEF00D, 0, 0);
        run("lb3",  1, 0, 2'd0, 3'd0, 32'h013, 32'h0, 32'h7F112233, 0, 0);
        run("tmo",  1, 0, 2'd0, 3'd2, 32'h200, 32'h0, 32'h0, 0, 1);
        run("nop",  0, 1, 2'd0, 3'd0, 32'h300, 32'h11111111, 32'h0, 0, 0);
        run("rw",   1, 1, 2'd3, 3'd2, 32'h30C, 32'h55AA55AA, 32'h0, 0, 0);
        run("lwmis",1, 0, 2'd0, 3'd2, 32'h102, 32'h0, 32'hA1B2C3D4, 0, 0);

        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        mem_ack = 0;
        chk("idleack.lv", 32'(load_valid), 32'd0);
        chk("idleack.req", 32'(mem_req), 32'd0);

        @(negedge clk);
        memread = 1; load_funct = 3'd2; addr = 32'h40;
        for (int c = 0; c < 5 && !mem_req; c++) begin
            @(negedge clk);
            #1;
        end
        chk("midrst.pre", 32'(mem_req), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst.req", 32'(mem_req), 32'd0);
        memread = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("midrst.post", 32'(mem_req), 32'd0);
        chk("midrst.lv", 32'(load_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
